p2s_frame_tx: RTL

P2S_FRAME_TX -- requirements
Module: p2s_frame_tx

---
 rtl/p2s_frame_tx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/p2s_frame_tx.sv
// Parallel-to-serial frame transmitter: shifts W-bit words out one bit per clock,
// with a one-word hold buffer and an optional forced idle gap between words.
module p2s_frame_tx #(
  parameter int W         = 4,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         so,
  output logic         so_vld,
  output logic         so_last,
  output logic         busy
);

  localparam int            CW          = $clog2(W);
  localparam logic [CW-1:0] LAST_IDX    = CW'(W - 1);
  localparam logic [CW-1:0] PRELAST_IDX = CW'(W - 2);
  localparam logic [3:0]    GAP_INIT    = 4'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_bitCnt;
  logic [3:0]    r_gapCnt;
  logic [W-1:0]  r_hold;
  logic          r_holdFull;
  logic          r_so;
  logic          r_soVld;
  logic          r_soLast;

  logic          w_accept;
  logic          w_lastBit;
  logic          w_loadHold;
  logic          w_loadIn;
  logic          w_toHold;
  logic          w_shiftStep;
  logic          w_gapStart;
  logic          w_gapDec;
  logic [W-1:0]  w_loadWord;
  logic          w_firstBit;
  logic          w_nextBit;
  logic [W-1:0]  w_shifted;

  assign in_ready  = rst_n & ~r_holdFull;
  assign w_accept  = in_valid & in_ready;
  assign w_lastBit = (r_bitCnt == LAST_IDX);

  assign so      = r_so;
  assign so_vld  = r_soVld;
  assign so_last = r_soLast;
  assign busy    = r_soVld | r_holdFull;

  // The held word always takes priority so accepted words leave in arrival order.
  assign w_loadWord = w_loadHold ? r_hold : in_data;
  assign w_firstBit = (MSB_FIRST != 0) ? w_loadWord[W-1] : w_loadWord[0];
  assign w_nextBit  = (MSB_FIRST != 0) ? r_shift[W-2] : r_shift[1];
  assign w_shifted  = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_loadHold  = 1'b0;
    w_loadIn    = 1'b0;
    w_shiftStep = 1'b0;
    w_gapStart  = 1'b0;
    w_gapDec    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_holdFull) begin
          w_loadHold  = 1'b1;
          w_stateNext = ST_SHIFT;
        end else if (w_accept) begin
          w_loadIn    = 1'b1;
          w_stateNext = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!w_lastBit) begin
          w_shiftStep = 1'b1;
        end else if (GAP != 0) begin
          w_gapStart  = 1'b1;
          w_stateNext = ST_GAP;
        end else if (r_holdFull) begin
          w_loadHold  = 1'b1;
        end else if (w_accept) begin
          w_loadIn    = 1'b1;
        end else begin
          w_stateNext = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gapCnt != 4'd0) begin
          w_gapDec    = 1'b1;
        end else if (r_holdFull) begin
          w_loadHold  = 1'b1;
          w_stateNext = ST_SHIFT;
        end else begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign w_toHold = w_accept & ~w_loadIn;

  // so already carries the current bit, so the shifter only feeds the following one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_gapCnt   <= '0;
      r_hold     <= '0;
      r_holdFull <= 1'b0;
      r_so       <= 1'b0;
      r_soVld    <= 1'b0;
      r_soLast   <= 1'b0;
    end else begin
      if (w_loadHold || w_loadIn) begin
        r_shift  <= w_loadWord;
        r_bitCnt <= '0;
        r_so     <= w_firstBit;
        r_soVld  <= 1'b1;
        r_soLast <= 1'b0;
      end else if (w_shiftStep) begin
        r_shift  <= w_shifted;
        r_bitCnt <= r_bitCnt + 1'b1;
        r_so     <= w_nextBit;
        r_soVld  <= 1'b1;
        r_soLast <= (r_bitCnt == PRELAST_IDX);
      end else begin
        r_bitCnt <= '0;
        r_so     <= 1'b0;
        r_soVld  <= 1'b0;
        r_soLast <= 1'b0;
      end

      if (w_gapStart) begin
        r_gapCnt <= GAP_INIT;
      end else if (w_gapDec) begin
        r_gapCnt <= r_gapCnt - 1'b1;
      end

      if (w_loadHold) begin
        r_holdFull <= 1'b0;
      end else if (w_toHold) begin
        r_hold     <= in_data;
        r_holdFull <= 1'b1;
      end
    end
  end

endmodule
